code_led_driver: RTL

CODE_LED_DRIVER -- requirements
Module: code_led_driver

---
 rtl/code_led_driver_pkg.sv | 45 ++++
 rtl/code_fifo.sv | 49 ++++
 rtl/code_led_driver.sv | 104 ++++++++++
 3 files changed

// File: rtl/code_led_driver_pkg.sv
// Shared definitions for the push-button code LED driver: code set, decode table, FSM states.
package code_led_driver_pkg;

   localparam int unsigned CODE_W     = 4;
   localparam int unsigned LED_W      = 8;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned PTR_W      = 2;
   localparam int unsigned LEVEL_W    = 3;

   localparam logic [CODE_W-1:0] CODE_L0    = 4'b1110;
   localparam logic [CODE_W-1:0] CODE_L1    = 4'b1101;
   localparam logic [CODE_W-1:0] CODE_L2    = 4'b1100;
   localparam logic [CODE_W-1:0] CODE_L3    = 4'b1011;
   localparam logic [CODE_W-1:0] CODE_L4    = 4'b1010;
   localparam logic [CODE_W-1:0] CODE_L5    = 4'b1001;
   localparam logic [CODE_W-1:0] CODE_L6    = 4'b1000;
   localparam logic [CODE_W-1:0] CODE_L7    = 4'b0111;
   localparam logic [CODE_W-1:0] CODE_BLANK = 4'b1111;

   typedef enum logic {
      IDLE = 1'b0,
      SHOW = 1'b1
   } state_t;

   // Everything from 0111 upward is in the code set; 0000..0110 are rejected.
   function automatic logic code_legal(input logic [CODE_W-1:0] c);
      return c >= CODE_L7;
   endfunction

   function automatic logic [LED_W-1:0] decode(input logic [CODE_W-1:0] c);
      case (c)
         CODE_L0:    decode = 8'hFE;
         CODE_L1:    decode = 8'hFD;
         CODE_L2:    decode = 8'hFB;
         CODE_L3:    decode = 8'hF7;
         CODE_L4:    decode = 8'hEF;
         CODE_L5:    decode = 8'hDF;
         CODE_L6:    decode = 8'hBF;
         CODE_L7:    decode = 8'h7F;
         CODE_BLANK: decode = 8'hFF;
         default:    decode = 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/code_fifo.sv
// 4-deep, 4-bit code FIFO; flags are registered and next occupancy is exported for look-ahead.
module code_fifo
   import code_led_driver_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic [CODE_W-1:0]  wr_data,
   output logic [CODE_W-1:0]  rd_data_c,
   output logic [LEVEL_W-1:0] level_next_c,
   output logic               full,
   output logic               empty
);

   logic [CODE_W-1:0]  mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [LEVEL_W-1:0] level;
   logic               do_push_c;
   logic               do_pop_c;

   assign do_push_c    = push && !full;
   assign do_pop_c     = pop && !empty;
   assign level_next_c = level + LEVEL_W'(do_push_c) - LEVEL_W'(do_pop_c);
   assign rd_data_c    = mem[rd_ptr];

   // Pointers, occupancy and flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
         level <= level_next_c;
         full  <= level_next_c == LEVEL_W'(FIFO_DEPTH);
         empty <= level_next_c == '0;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push_c) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/code_led_driver.sv
// Queues push-button codes and shows each on an active-low one-hot LED bank for a fixed number of ticks.
module code_led_driver
   import code_led_driver_pkg::*;
#(
   parameter int unsigned CLK_DIV     = 2000,
   parameter int unsigned DWELL_TICKS = 250
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       code_valid,
   input  logic [3:0] code,
   output logic       code_ready,
   output logic [7:0] out_n,
   output logic       busy,
   output logic       err
);

   localparam int unsigned CNT_W = 16;

   logic [CNT_W-1:0]   pre_cnt;
   logic [CNT_W-1:0]   dwell;
   logic [CNT_W-1:0]   dwell_next_c;
   logic               tick_c;
   logic               accept_c;
   logic               legal_c;
   logic               push_c;
   logic               pop_c;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CODE_W-1:0]  head_c;
   logic [LEVEL_W-1:0] level_next_c;
   state_t             state;
   state_t             state_next_c;

   assign tick_c   = pre_cnt == CNT_W'(CLK_DIV - 1);
   assign accept_c = code_valid && code_ready;
   assign legal_c  = code_legal(code);
   assign push_c   = accept_c && legal_c && !fifo_full;

   // Free-running tick prescaler.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      pre_cnt <= '0;
      else if (tick_c) pre_cnt <= '0;
      else             pre_cnt <= pre_cnt + CNT_W'(1);
   end

   code_fifo u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push         (push_c),
      .pop          (pop_c),
      .wr_data      (code),
      .rd_data_c    (head_c),
      .level_next_c (level_next_c),
      .full         (fifo_full),
      .empty        (fifo_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next_c;
   end

   always_comb begin
      state_next_c = state;
      case (state)
         IDLE: if (!fifo_empty) state_next_c = SHOW;
         SHOW: if (tick_c && dwell == CNT_W'(DWELL_TICKS - 1)) state_next_c = IDLE;
         default: state_next_c = IDLE;
      endcase
   end

   always_comb begin
      pop_c        = 1'b0;
      dwell_next_c = dwell;
      case (state)
         IDLE: if (!fifo_empty) begin
            pop_c        = 1'b1;
            dwell_next_c = '0;
         end
         SHOW: if (tick_c) dwell_next_c = dwell + CNT_W'(1);
         default: ;
      endcase
   end

   // Registered outputs use next-cycle occupancy/state so they match the FIFO and FSM exactly.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dwell      <= '0;
         out_n      <= 8'hFF;
         code_ready <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
      end else begin
         dwell      <= dwell_next_c;
         if (pop_c) out_n <= decode(head_c);
         code_ready <= level_next_c != LEVEL_W'(FIFO_DEPTH);
         busy       <= (state_next_c == SHOW) || (level_next_c != '0);
         err        <= accept_c && !legal_c;
      end
   end

endmodule
